ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameters: AW, default 6, address width; DW, default 8, data width.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have, per requester n=0,1: reqn in 1 (request); wen in 1 (1=write, 0=read); addrn in AW; wdatan in DW; gntn out 1 (accept pulse); rvalidn out 1 (read data valid pulse); rdatan out DW (read data).
REQ-005 SHALL have RAM-side ports: ram_cs out 1; ram_we out 1; ram_re out 1; ram_addr out AW; ram_data_in out DW; ram_data_out in DW, valid the cycle after the ram_re cycle.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-007 IDLE: if reqn is high for any n, SHALL pick a winner, latch its we/addr/wdata, pulse its gnt for that cycle only, and go to ISSUE; with no request, SHALL stay in IDLE.
REQ-008 Arbitration SHALL be round-robin: a single requester wins; with both requesting, the one not granted last wins; after reset, requester 0 has priority.
REQ-009 SHALL arbitrate only in IDLE; requests in ISSUE/WAIT SHALL wait, with no gnt, until the next IDLE.
REQ-010 Requester SHALL hold req and command stable until its gnt cycle; the command sampled in the gnt cycle is the one executed.
REQ-011 ISSUE: SHALL drive, registered, for exactly one cycle: ram_cs=1; ram_addr=latched addr; for write, ram_we=1, ram_re=0, ram_data_in=latched wdata; for read, ram_re=1, ram_we=0, ram_data_in=0.
REQ-012 After ISSUE, a write SHALL return to IDLE; a read SHALL go to WAIT.
REQ-013 WAIT: SHALL capture ram_data_out into rdata of the owning requester, pulse that requester's rvalid for one cycle on the next cycle, and go to IDLE.
REQ-014 Timing, gnt at cycle T: RAM command at T+1; read rvalid at T+3; next gnt earliest at T+2 (after a write) or T+3 (after a read).
REQ-015 Outside ISSUE, ram_cs, ram_we and ram_re SHALL be 0, and ram_addr and ram_data_in SHALL be 0.
REQ-016 rdatan SHALL hold its last captured value until the next read for that requester; the other requester's rdata SHALL be unaffected.
REQ-017 gnt0 and gnt1 SHALL never both be high; rvalid0 and rvalid1 SHALL never both be high.
REQ-018 req dropped before gnt SHALL be ignored, with no side effect.

Reset
REQ-019 On rst=1 at a clock edge: state=IDLE; gnt*, rvalid*, ram_cs, ram_we, ram_re = 0; ram_addr, ram_data_in, rdata* = 0; round-robin pointer favours requester 0.
REQ-020 Reset mid-operation SHALL abort the transaction: no rvalid issued; a RAM command already driven in the reset cycle is not retracted.
REQ-021 rst has priority over every request in the same cycle; no gnt in a reset cycle.

Structure
REQ-022 Shared package ram_arb_pkg SHALL hold AW, DW defaults and the FSM state enum (IDLE, ISSUE, WAIT).
REQ-023 Round-robin pick SHALL be a sub-module rr_arb2 (inputs req[1:0] and last-grant; output one-hot grant), combinational, with the pointer register kept in ram_port_arbiter.

Verification
REQ-024 After reset, req0 write addr 5, data 0xAA -> gnt0 at T; at T+1, ram_cs=1, ram_we=1, ram_addr=5, ram_data_in=0xAA; back in IDLE at T+2.
REQ-025 req1 read addr 5, RAM returns 0xAA -> gnt1 at T, ram_re=1 at T+1, rvalid1=1 and rdata1=0xAA at T+3; rvalid0 stays 0.
REQ-026 req0 and req1 held high with writes to addr 10 (0x55) and addr 20 (0xEE) -> grants alternate 0,1,0,1; gnt never concurrent.
REQ-027 Request during WAIT -> no gnt until IDLE; gnt in the IDLE cycle after rvalid.
REQ-028 rst asserted in WAIT of a read -> no rvalid; all outputs 0 next cycle; next simultaneous request is granted to requester 0.
REQ-029 req1 pulsed one cycle while busy in ISSUE -> never granted; no RAM access.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-requester RAM port arbiter:
//   - AW_DEFAULT / DW_DEFAULT : default address and data widths
//   - state_t                 : arbiter FSM state encoding (IDLE, ISSUE, WAIT)
//   - other_req()             : index of the requester that is not 'idx'
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int AW_DEFAULT = 6;
    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // With only two requesters the "other" one is just the complement.
    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
// Bundles both requester ports and the RAM-side port of the arbiter.
//   Requester n (n = 0,1):
//     reqn, wen, addrn, wdatan  : command from requester
//     gntn                      : one-cycle accept pulse
//     rvalidn, rdatan           : read-return pulse and held read data
//   RAM side:
//     ram_cs, ram_we, ram_re, ram_addr, ram_data_in : registered command
//     ram_data_out                                 : read data, valid the
//                                                    cycle after ram_re
// Modports:
//   slave  : the arbiter (receives requests, drives the RAM)
//   master : the requesters + RAM model (drive requests, return RAM data)
//
// Handshake: a requester raises reqn with a stable command and holds it until
// the cycle in which gntn is high; the command present in that cycle is the
// one executed. Dropping reqn before gntn withdraws the request. For reads,
// rvalidn pulses once with rdatan carrying the data; rdatan holds afterwards.
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 8
) ();

    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic          ram_cs;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output ram_cs, ram_we, ram_re, ram_addr, ram_data_in,
        input  ram_data_out
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  ram_cs, ram_we, ram_re, ram_addr, ram_data_in,
        output ram_data_out
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   i_req[1:0] : pending requests
//   i_last     : index of the requester granted most recently
//   o_gnt[1:0] : one-hot pick (all zero when nothing is requested)
// A lone requester always wins; on a tie the requester that was not granted
// last wins.
// ---------------------------------------------------------------------------
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (other_req(i_last) == 1'b1) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM between two requesters.
//   clk     : single clock, rising edge
//   rst     : synchronous, active-high reset
//   bus     : ram_port_arbiter_if.slave (both requesters + RAM side)
//   o_state : current FSM state, for observation
//
// Flow for a grant in cycle T:
//   T   IDLE  : winner picked, gnt pulsed, command latched into RAM regs
//   T+1 ISSUE : registered RAM command visible on ram_*
//   T+2 IDLE (write) or WAIT (read: ram_data_out captured at end of cycle)
//   T+3 read  : rvalid pulses for the owner, FSM back in IDLE
// ---------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus,
    output state_t              o_state
);

    state_t        r_state;
    state_t        w_next_state;

    logic          r_last;     // index of requester granted most recently
    logic          r_owner;    // requester owning the in-flight command
    logic          r_we;       // in-flight command is a write

    logic          r_ram_cs;
    logic          r_ram_we;
    logic          r_ram_re;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_data_in;

    logic [1:0]    r_rvalid;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic [1:0]    w_req;
    logic [1:0]    w_pick;
    logic [1:0]    w_gnt;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_req = {bus.req1, bus.req0};

    rr_arb2 u_rr_arb2 (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // Command of the winner; only meaningful when w_gnt is non-zero.
    assign w_sel_we    = w_gnt[1] ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_gnt[1] ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_gnt[1] ? bus.wdata1 : bus.wdata0;

    // Next-state and grant decode. Grants are suppressed during reset so a
    // request coinciding with rst is never accepted.
    always_comb begin
        w_next_state = r_state;
        w_gnt        = 2'b00;
        case (r_state)
            IDLE: begin
                if (!rst && (w_pick != 2'b00)) begin
                    w_gnt        = w_pick;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = r_we ? IDLE : WAIT;
            end
            WAIT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last        <= 1'b1;   // makes requester 0 win the first tie
            r_owner       <= 1'b0;
            r_we          <= 1'b0;
            r_ram_cs      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_re      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_rvalid      <= 2'b00;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            r_state <= w_next_state;

            // RAM command regs are zero except in the single ISSUE cycle.
            r_ram_cs      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_re      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_rvalid      <= 2'b00;

            if (w_gnt != 2'b00) begin
                r_last        <= w_gnt[1];
                r_owner       <= w_gnt[1];
                r_we          <= w_sel_we;
                r_ram_cs      <= 1'b1;
                r_ram_we      <= w_sel_we;
                r_ram_re      <= ~w_sel_we;
                r_ram_addr    <= w_sel_addr;
                r_ram_data_in <= w_sel_we ? w_sel_wdata : '0;
            end

            // RAM read data is valid during WAIT; capture it for the owner.
            if (r_state == WAIT) begin
                if (r_owner) begin
                    r_rdata1    <= bus.ram_data_out;
                    r_rvalid[1] <= 1'b1;
                end else begin
                    r_rdata0    <= bus.ram_data_out;
                    r_rvalid[0] <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt0        = w_gnt[0];
    assign bus.gnt1        = w_gnt[1];
    assign bus.rvalid0     = r_rvalid[0];
    assign bus.rvalid1     = r_rvalid[1];
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;
    assign bus.ram_cs      = r_ram_cs;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_re      = r_ram_re;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_data_in = r_ram_data_in;

    assign o_state = r_state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 ns later, so each step below is one clock cycle.
// A small behavioural RAM answers reads one cycle after ram_re.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 6;
    localparam int DW = 8;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     checks;
    int     errors;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_data_in;
        bus.ram_data_out <= (bus.ram_cs && bus.ram_re) ? mem[bus.ram_addr] : '0;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // gnt and rvalid mutual exclusion, every cycle
    always @(negedge clk) begin
        #2;
        chk1("gnt_excl", bus.gnt0 & bus.gnt1, 1'b0);
        chk1("rvalid_excl", bus.rvalid0 & bus.rvalid1, 1'b0);
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.ram_data_out = '0;

        // ---- reset: requests during reset are never granted
        @(negedge clk); bus.req0 = 1'b1; bus.req1 = 1'b1; #1;
        chk1("rst_gnt0", bus.gnt0, 1'b0);
        chk1("rst_gnt1", bus.gnt1, 1'b0);
        @(negedge clk); #1;
        chkv("rst_state", 32'(dbg_state), 32'(IDLE));
        chk1("rst_cs", bus.ram_cs, 1'b0);
        chk1("rst_we", bus.ram_we, 1'b0);
        chk1("rst_re", bus.ram_re, 1'b0);
        chkv("rst_addr", 32'(bus.ram_addr), 32'd0);
        chkv("rst_din", 32'(bus.ram_data_in), 32'd0);
        chkv("rst_rdata0", 32'(bus.rdata0), 32'd0);
        chkv("rst_rdata1", 32'(bus.rdata1), 32'd0);
        chk1("rst_rvalid0", bus.rvalid0, 1'b0);
        chk1("rst_rvalid1", bus.rvalid1, 1'b0);
        chk1("rst_gnt0_b", bus.gnt0, 1'b0);
        @(negedge clk); rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0; #1;
        chk1("idle_gnt0", bus.gnt0, 1'b0);
        chkv("idle_state", 32'(dbg_state), 32'(IDLE));

        // ---- write by requester 0: addr 5, data AA
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd5; bus.wdata0 = 8'hAA; #1;
        chk1("wr_gnt0", bus.gnt0, 1'b1);
        chk1("wr_gnt1", bus.gnt1, 1'b0);
        chk1("wr_cs_T", bus.ram_cs, 1'b0);
        @(negedge clk); bus.req0 = 1'b0; #1;
        chkv("wr_state_T1", 32'(dbg_state), 32'(ISSUE));
        chk1("wr_cs", bus.ram_cs, 1'b1);
        chk1("wr_we", bus.ram_we, 1'b1);
        chk1("wr_re", bus.ram_re, 1'b0);
        chkv("wr_addr", 32'(bus.ram_addr), 32'd5);
        chkv("wr_din", 32'(bus.ram_data_in), 32'hAA);
        chk1("wr_gnt0_T1", bus.gnt0, 1'b0);
        @(negedge clk); #1;
        chkv("wr_state_T2", 32'(dbg_state), 32'(IDLE));
        chk1("wr_cs_T2", bus.ram_cs, 1'b0);
        chkv("wr_addr_T2", 32'(bus.ram_addr), 32'd0);
        chkv("wr_din_T2", 32'(bus.ram_data_in), 32'd0);

        // ---- read by requester 1: addr 5 -> AA
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd5; bus.wdata1 = 8'h3C; #1;
        chk1("rd_gnt1", bus.gnt1, 1'b1);
        chk1("rd_gnt0", bus.gnt0, 1'b0);
        @(negedge clk); bus.req1 = 1'b0; #1;
        chk1("rd_cs", bus.ram_cs, 1'b1);
        chk1("rd_re", bus.ram_re, 1'b1);
        chk1("rd_we", bus.ram_we, 1'b0);
        chkv("rd_addr", 32'(bus.ram_addr), 32'd5);
        chkv("rd_din", 32'(bus.ram_data_in), 32'd0);
        @(negedge clk); #1;
        chkv("rd_state_T2", 32'(dbg_state), 32'(WAIT));
        chk1("rd_cs_T2", bus.ram_cs, 1'b0);
        chk1("rd_rvalid1_T2", bus.rvalid1, 1'b0);
        @(negedge clk); #1;
        chk1("rd_rvalid1", bus.rvalid1, 1'b1);
        chkv("rd_rdata1", 32'(bus.rdata1), 32'hAA);
        chk1("rd_rvalid0", bus.rvalid0, 1'b0);
        chkv("rd_rdata0", 32'(bus.rdata0), 32'd0);
        chkv("rd_state_T3", 32'(dbg_state), 32'(IDLE));
        @(negedge clk); #1;
        chk1("rd_rvalid1_T4", bus.rvalid1, 1'b0);
        chkv("rd_rdata1_hold", 32'(bus.rdata1), 32'hAA);

        // ---- both requesters held: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd10; bus.wdata0 = 8'h55;
                bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd20; bus.wdata1 = 8'hEE;
            end
            #1;
            chk1("rr_gnt0", bus.gnt0, ~k[0]);
            chk1("rr_gnt1", bus.gnt1, k[0]);
            @(negedge clk);
            if (k == 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
            #1;
            chk1("rr_busy_gnt0", bus.gnt0, 1'b0);
            chk1("rr_busy_gnt1", bus.gnt1, 1'b0);
            chkv("rr_addr", 32'(bus.ram_addr), k[0] ? 32'd20 : 32'd10);
            chkv("rr_din", 32'(bus.ram_data_in), k[0] ? 32'hEE : 32'h55);
        end

        // ---- request arriving in WAIT is held off until IDLE
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd10; #1;
        chk1("w_gnt0", bus.gnt0, 1'b1);
        @(negedge clk); bus.req0 = 1'b0; #1;
        chk1("w_re", bus.ram_re, 1'b1);
        chkv("w_addr", 32'(bus.ram_addr), 32'd10);
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd30; bus.wdata1 = 8'h33; #1;
        chkv("w_state", 32'(dbg_state), 32'(WAIT));
        chk1("w_gnt1_wait", bus.gnt1, 1'b0);
        @(negedge clk); #1;
        chk1("w_rvalid0", bus.rvalid0, 1'b1);
        chkv("w_rdata0", 32'(bus.rdata0), 32'h55);
        chkv("w_rdata1_kept", 32'(bus.rdata1), 32'hAA);
        chk1("w_gnt1_idle", bus.gnt1, 1'b1);
        @(negedge clk); bus.req1 = 1'b0; #1;
        chk1("w_ram_we", bus.ram_we, 1'b1);
        chkv("w_ram_addr", 32'(bus.ram_addr), 32'd30);
        chkv("w_ram_din", 32'(bus.ram_data_in), 32'h33);
        chk1("w_rvalid0_off", bus.rvalid0, 1'b0);
        @(negedge clk); #1;
        chkv("w_state_end", 32'(dbg_state), 32'(IDLE));

        // ---- one-cycle req1 pulse during ISSUE is ignored
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd7; bus.wdata0 = 8'h11; #1;
        chk1("p_gnt0", bus.gnt0, 1'b1);
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd40; bus.wdata1 = 8'h99; #1;
        chk1("p_gnt1_issue", bus.gnt1, 1'b0);
        chkv("p_addr", 32'(bus.ram_addr), 32'd7);
        @(negedge clk); bus.req1 = 1'b0; #1;
        chk1("p_gnt1_after", bus.gnt1, 1'b0);
        chk1("p_cs_after", bus.ram_cs, 1'b0);
        chkv("p_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk); #1;
        chk1("p_cs_none", bus.ram_cs, 1'b0);
        chk1("p_gnt1_none", bus.gnt1, 1'b0);

        // ---- reset during WAIT of a read aborts it
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd20; #1;
        chk1("r_gnt1", bus.gnt1, 1'b1);
        @(negedge clk); bus.req1 = 1'b0; #1;
        chk1("r_re", bus.ram_re, 1'b1);
        chkv("r_addr", 32'(bus.ram_addr), 32'd20);
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd1; bus.wdata0 = 8'h77;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd2; bus.wdata1 = 8'h88; #1;
        chkv("r_state_wait", 32'(dbg_state), 32'(WAIT));
        chk1("r_gnt0_rst", bus.gnt0, 1'b0);
        chk1("r_gnt1_rst", bus.gnt1, 1'b0);
        @(negedge clk);
        rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0; #1;
        chk1("r_rvalid1", bus.rvalid1, 1'b0);
        chk1("r_rvalid0", bus.rvalid0, 1'b0);
        chkv("r_rdata1", 32'(bus.rdata1), 32'd0);
        chkv("r_rdata0", 32'(bus.rdata0), 32'd0);
        chk1("r_cs", bus.ram_cs, 1'b0);
        chk1("r_re_off", bus.ram_re, 1'b0);
        chkv("r_addr_off", 32'(bus.ram_addr), 32'd0);
        chkv("r_state_idle", 32'(dbg_state), 32'(IDLE));
        @(negedge clk); bus.req0 = 1'b1; bus.req1 = 1'b1; #1;
        chk1("r_tie_gnt0", bus.gnt0, 1'b1);
        chk1("r_tie_gnt1", bus.gnt1, 1'b0);
        chk1("r_rvalid1_late", bus.rvalid1, 1'b0);
        @(negedge clk); bus.req0 = 1'b0; bus.req1 = 1'b0; #1;
        chk1("r_post_we", bus.ram_we, 1'b1);
        chkv("r_post_addr", 32'(bus.ram_addr), 32'd1);
        chkv("r_post_din", 32'(bus.ram_data_in), 32'h77);
        @(negedge clk); #1;
        chk1("r_post_cs_off", bus.ram_cs, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
